// File: rtl/udma_i2c_pkg.sv
// Shared definitions for the uDMA I2C receive path: word size encodings,
// the packer state enum and the size-to-byte-count decode.
package udma_i2c_pkg;

  localparam logic [1:0] SIZE_8  = 2'd0;
  localparam logic [1:0] SIZE_16 = 2'd1;
  localparam logic [1:0] SIZE_32 = 2'd2;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ACC  = 2'd1,
    ST_FULL = 2'd2
  } rx_pack_state_e;

  // Reserved encoding 3 packs a full 32-bit word, same as SIZE_32.
  function automatic logic [2:0] size_to_n(input logic [1:0] size);
    case (size)
      SIZE_8:  size_to_n = 3'd1;
      SIZE_16: size_to_n = 3'd2;
      SIZE_32: size_to_n = 3'd4;
      default: size_to_n = 3'd4;
    endcase
  endfunction

endpackage

// File: rtl/udma_i2c_rx_pack.sv
// Packs received I2C bytes little-endian into 1/2/4-byte words for the uDMA
// RX channel, with a one-word output slot and an accumulator that can hold a
// completed word while the slot is still occupied.
//
// state   | meaning
// --------+----------------------------------------------------------
// ST_IDLE | accumulator empty, next accepted byte starts a new word
// ST_ACC  | accumulator holds 0 < count < N bytes
// ST_FULL | accumulator holds a finished word, output slot occupied
module udma_i2c_rx_pack
  import udma_i2c_pkg::*;
(
  input  logic        clk_i,
  input  logic        rstn_i,
  input  logic        sw_rst_i,
  input  logic [1:0]  cfg_size_i,
  input  logic        flush_i,
  input  logic [7:0]  byte_data_i,
  input  logic        byte_valid_i,
  output logic        byte_ready_o,
  output logic [31:0] word_data_o,
  output logic [1:0]  word_bytes_o,
  output logic        word_valid_o,
  input  logic        word_ready_i,
  output logic        busy_o
);

  rx_pack_state_e state_q, state_d;

  logic [1:0]  count_q, count_d;
  logic [2:0]  n_q, n_d;
  logic [31:0] acc_q, acc_d;
  logic [1:0]  pend_bytes_q, pend_bytes_d;
  logic        slot_valid_q, slot_valid_d;
  logic [31:0] slot_data_q, slot_data_d;
  logic [1:0]  slot_bytes_q, slot_bytes_d;

  logic        byte_accept;
  logic [2:0]  eff_n;
  logic [2:0]  new_count;
  logic [2:0]  new_bytes;
  logic [31:0] lane_word;
  logic [31:0] merged;
  logic        word_done;
  logic        slot_free;

  assign byte_ready_o = (state_q != ST_FULL) || sw_rst_i;
  assign byte_accept  = byte_valid_i && byte_ready_o && !sw_rst_i;

  // The word length is sampled only with the first byte of each word.
  assign eff_n     = (count_q == 2'd0) ? size_to_n(cfg_size_i) : n_q;
  assign lane_word = {24'd0, byte_data_i} << {count_q, 3'b000};
  assign merged    = byte_accept ? (acc_q | lane_word) : acc_q;
  assign new_count = {1'b0, count_q} + {2'b00, byte_accept};
  assign new_bytes = new_count - 3'd1;
  assign slot_free = !slot_valid_q || word_ready_i;
  assign word_done = (state_q != ST_FULL) && (new_count != 3'd0) &&
                     ((byte_accept && (new_count == eff_n)) || flush_i);

  always_comb begin
    state_d      = state_q;
    count_d      = count_q;
    n_d          = n_q;
    acc_d        = acc_q;
    pend_bytes_d = pend_bytes_q;
    slot_valid_d = slot_valid_q && !word_ready_i;
    slot_data_d  = slot_data_q;
    slot_bytes_d = slot_bytes_q;

    if (sw_rst_i) begin
      state_d      = ST_IDLE;
      count_d      = 2'd0;
      n_d          = 3'd0;
      acc_d        = 32'd0;
      pend_bytes_d = 2'd0;
      slot_valid_d = 1'b0;
      slot_data_d  = 32'd0;
      slot_bytes_d = 2'd0;
    end else begin
      unique case (state_q)
        ST_FULL: begin
          if (word_ready_i) begin
            slot_valid_d = 1'b1;
            slot_data_d  = acc_q;
            slot_bytes_d = pend_bytes_q;
            acc_d        = 32'd0;
            state_d      = ST_IDLE;
          end
        end
        default: begin
          if (byte_accept && (count_q == 2'd0)) begin
            n_d = eff_n;
          end
          if (word_done) begin
            count_d = 2'd0;
            if (slot_free) begin
              slot_valid_d = 1'b1;
              slot_data_d  = merged;
              slot_bytes_d = new_bytes[1:0];
              acc_d        = 32'd0;
              state_d      = ST_IDLE;
            end else begin
              // Park the finished word until the slot drains.
              acc_d        = merged;
              pend_bytes_d = new_bytes[1:0];
              state_d      = ST_FULL;
            end
          end else begin
            acc_d   = merged;
            count_d = new_count[1:0];
            state_d = (new_count != 3'd0) ? ST_ACC : ST_IDLE;
          end
        end
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      count_q      <= 2'd0;
      n_q          <= 3'd0;
      acc_q        <= 32'd0;
      pend_bytes_q <= 2'd0;
      slot_valid_q <= 1'b0;
      slot_data_q  <= 32'd0;
      slot_bytes_q <= 2'd0;
    end else begin
      count_q      <= count_d;
      n_q          <= n_d;
      acc_q        <= acc_d;
      pend_bytes_q <= pend_bytes_d;
      slot_valid_q <= slot_valid_d;
      slot_data_q  <= slot_data_d;
      slot_bytes_q <= slot_bytes_d;
    end
  end

  assign word_valid_o = slot_valid_q;
  assign word_data_o  = slot_data_q;
  assign word_bytes_o = slot_bytes_q;
  assign busy_o       = (state_q != ST_IDLE) || slot_valid_q;

endmodule
